reg_file_param: RTL and testbench

//  Parametrised successor of the 16x16 CPU register file. Two async read ports,
//  one general write port, and a dedicated R0 (accumulator) write port.

---
 rtl/reg_file_param.sv | 138 +++++++++++++
 tb/tb_reg_file_param.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// reg_file_param: parametrised CPU register file with a sequential post-reset clear.
//
// Two combinational read ports, one general write port and a dedicated R0
// (accumulator) write port. After reset the storage is cleared one entry per
// cycle; ready goes high once every entry has been cleared. Until then, and
// while reset is high, reads return zero and all writes are dropped.
//
// Optional feature (macro REGFILE_BYPASS_EN): same-cycle write-to-read bypass.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   add1/add2 read addresses; r1data/r2data combinational read data
//   r0data    continuous view of entry 0
//   wadd/wdata/regwrite  general write port
//   wr0/r0write          dedicated R0 write port (wins over regwrite to entry 0)
//   ready     registered, 1 = clear finished and writes accepted
module reg_file_param #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] add1,
    input  logic [ADDR_W-1:0] add2,
    output logic [DATA_W-1:0] r1data,
    output logic [DATA_W-1:0] r2data,
    output logic [DATA_W-1:0] r0data,
    input  logic [ADDR_W-1:0] wadd,
    input  logic [DATA_W-1:0] wdata,
    input  logic              regwrite,
    input  logic [DATA_W-1:0] wr0,
    input  logic              r0write,
    output logic              ready
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        READY = 2'd1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                rd_en;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
        end
    end

    // Next state: walk clr_idx across every entry, then settle in READY
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = ADDR_W'(clr_idx_q + 1'b1);
                if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = READY;
                    ready_d = 1'b1;
                end
            end
            READY: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d   = CLEAR;
                clr_idx_d = '0;
                ready_d   = 1'b0;
            end
        endcase
    end

    // Storage: untouched by reset itself; the clear engine zeroes it afterwards.
    // The r0write assignment comes last so it overrides regwrite to entry 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem_q[clr_idx_q] <= '0;
            end else if (state_q == READY) begin
                if (regwrite) begin
                    mem_q[wadd] <= wdata;
                end
                if (r0write) begin
                    mem_q[0] <= wr0;
                end
            end
        end
    end

    assign rd_en = !reset && (state_q == READY);
    assign ready = ready_q;

    // Read ports: zero until the file is usable
    always_comb begin
        r1data = '0;
        r2data = '0;
        r0data = '0;
        if (rd_en) begin
            r1data = mem_q[add1];
            r2data = mem_q[add2];
            r0data = mem_q[0];
`ifdef REGFILE_BYPASS_EN
            // Forward the committing write; r0write has priority at address 0
            if (regwrite && (wadd == add1)) begin
                r1data = wdata;
            end
            if (r0write && (add1 == '0)) begin
                r1data = wr0;
            end
            if (regwrite && (wadd == add2)) begin
                r2data = wdata;
            end
            if (r0write && (add2 == '0)) begin
                r2data = wr0;
            end
            if (r0write) begin
                r0data = wr0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: a behavioural register-file model is checked against
// the DUT on every falling edge, plus directed literal checks of the key scenarios.
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  add1, add2, wadd;
    logic [15:0] wdata, wr0;
    logic        regwrite, r0write;
    logic [15:0] r1data, r2data, r0data;
    logic        ready;

    int errors = 0;
    int checks = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    reg_file_param #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .add1     (add1),
        .add2     (add2),
        .r1data   (r1data),
        .r2data   (r2data),
        .r0data   (r0data),
        .wadd     (wadd),
        .wdata    (wdata),
        .regwrite (regwrite),
        .wr0      (wr0),
        .r0write  (r0write),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    // Model: file is usable once 16 consecutive non-reset edges have elapsed
    logic [15:0] m_mem [16];
    int          m_low_edges = 0;
    bit          m_ready = 1'b0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_low_edges = 0;
            m_ready     = 1'b0;
            started     = 1'b1;
        end else if (started && !m_ready) begin
            m_mem[m_low_edges] = 16'h0000;
            m_low_edges = m_low_edges + 1;
            if (m_low_edges == 16) m_ready = 1'b1;
        end else if (m_ready) begin
            if (regwrite) m_mem[wadd] = wdata;
            if (r0write)  m_mem[0]    = wr0;
        end
    end

    function automatic logic [15:0] exp_rd(input logic [3:0] a);
        if (reset || !m_ready) return 16'h0000;
        if (BYP && r0write && a == 4'd0) return wr0;
        if (BYP && regwrite && wadd == a) return wdata;
        return m_mem[a];
    endfunction

    function automatic logic [15:0] exp_r0();
        if (reset || !m_ready) return 16'h0000;
        if (BYP && r0write) return wr0;
        return m_mem[0];
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous compare against the model
    always @(negedge clk) begin
        if (started) begin
            chk("model_ready",  {15'd0, ready}, {15'd0, m_ready});
            chk("model_r1data", r1data, exp_rd(add1));
            chk("model_r2data", r2data, exp_rd(add2));
            chk("model_r0data", r0data, exp_r0());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; add1 = '0; add2 = '0; wadd = '0; wdata = '0;
        regwrite = 1'b0; wr0 = '0; r0write = 1'b0;

        // Reset for two cycles, then clear with writes attempted throughout
        tick(); tick();
        #1 chk("reset_ready", {15'd0, ready}, 16'd0);
        chk("reset_r1data", r1data, 16'h0000);
        reset = 1'b0;
        regwrite = 1'b1; wadd = 4'd3; wdata = 16'hFFFF;
        r0write = 1'b1; wr0 = 16'hFFFF;
        add1 = 4'd3; add2 = 4'd0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 16) begin regwrite = 1'b0; r0write = 1'b0; end
            #1;
            chk("clr_ready",  {15'd0, ready}, (k == 16) ? 16'd1 : 16'd0);
            chk("clr_r1data", r1data, 16'h0000);
            chk("clr_r0data", r0data, 16'h0000);
        end

        // Reset mid-clear at clr_idx=7
        reset = 1'b1; tick(); reset = 1'b0;
        for (int k = 1; k <= 7; k++) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick(); #1;
            chk("midclr_ready", {15'd0, ready}, (k == 16) ? 16'd1 : 16'd0);
        end

        // Plain write then read
        regwrite = 1'b1; wadd = 4'd5; wdata = 16'hA5A5;
        tick(); regwrite = 1'b0; add1 = 4'd5; #1;
        chk("wr5_r1data", r1data, 16'hA5A5);
        add2 = 4'd3; #1;
        chk("clrdrop_r2data", r2data, 16'h0000);

        // Same-edge collision on entry 0: r0write wins
        regwrite = 1'b1; wadd = 4'd0; wdata = 16'h1111;
        r0write = 1'b1; wr0 = 16'h2222;
        tick(); regwrite = 1'b0; r0write = 1'b0; add1 = 4'd0; #1;
        chk("coll_r0data", r0data, 16'h2222);
        chk("coll_r1data", r1data, 16'h2222);

        // Same-edge writes to distinct entries both commit
        regwrite = 1'b1; wadd = 4'd9; wdata = 16'h0F0F;
        r0write = 1'b1; wr0 = 16'h00FF;
        tick(); regwrite = 1'b0; r0write = 1'b0; add1 = 4'd9; add2 = 4'd0; #1;
        chk("dual_r1data", r1data, 16'h0F0F);
        chk("dual_r2data", r2data, 16'h00FF);
        add1 = 4'd5; add2 = 4'd5; #1;
        chk("same_addr_r1", r1data, 16'hA5A5);
        chk("same_addr_r2", r2data, 16'hA5A5);

        // Same-cycle read of an entry being written
        regwrite = 1'b1; wadd = 4'd4; wdata = 16'h1234;
        tick();
        wdata = 16'hBEEF; add1 = 4'd4; #1;
        chk("bypass_r1data", r1data, BYP ? 16'hBEEF : 16'h1234);
        tick(); regwrite = 1'b0; #1;
        chk("after_wr4_r1data", r1data, 16'hBEEF);

        // Reset while READY: reads drop to zero at once, ready falls after the edge
        reset = 1'b1; #1;
        chk("rst_ready_r1data", r1data, 16'h0000);
        chk("rst_ready_r0data", r0data, 16'h0000);
        tick();
        chk("rst_ready_flag", {15'd0, ready}, 16'd0);
        reset = 1'b0;
        tick(); tick();

        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
